lane_stripe_ctrl: RTL and testbench

LANE_STRIPE_CTRL -- requirements
Module: lane_stripe_ctrl

---
 rtl/lane_stripe_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lane_stripe_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_stripe_ctrl.sv
// lane_stripe_ctrl
//   Stripes an upstream byte stream alternately across two lane FIFOs
//   (lane 0, lane 1, lane 0, ...). Each lane FIFO is show-ahead, so its head
//   byte is visible on dataoutK whenever validoutK is high. A three-state FSM
//   (IDLE / STRIPE / DRAIN) tracks a burst. The flush input closes the burst.
//   Once both FIFOs have drained, the FSM re-arms so the next burst starts on
//   lane 0.
//
// Ports
//   clk_4f        in   clock, rising edge
//   reset_L       in   asynchronous active-low reset
//   valid_in      in   upstream byte valid
//   data_in[7:0]  in   upstream byte
//   ready_out     out  byte accepted this cycle when valid_in is also high
//   flush         in   close current burst and drain
//   lane0_ready   in   lane 0 consumer takes the head byte this cycle
//   lane1_ready   in   lane 1 consumer takes the head byte this cycle
//   validout0/1   out  lane FIFO head valid
//   dataout0/1    out  lane FIFO head byte
//   sel_lane      out  lane that receives the next accepted byte
//   state_out     out  FSM state: 0 IDLE, 1 STRIPE, 2 DRAIN
//   byte_cnt      out  free-running count of accepted bytes (wraps)
module lane_stripe_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic        clk_4f,
  input  logic        reset_L,
  input  logic        valid_in,
  input  logic [7:0]  data_in,
  output logic        ready_out,
  input  logic        flush,
  input  logic        lane0_ready,
  input  logic        lane1_ready,
  output logic        validout0,
  output logic        validout1,
  output logic [7:0]  dataout0,
  output logic [7:0]  dataout1,
  output logic        sel_lane,
  output logic [1:0]  state_out,
  output logic [15:0] byte_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STRIPE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic        sel_reg, sel_next;
  logic [15:0] cnt_reg, cnt_next;

  logic            accept;
  logic [1:0]      full;
  logic [1:0]      empty;
  logic [1:0]      push;
  logic [1:0]      pop;
  logic [1:0]      lane_ready;
  logic [1:0][7:0] head;

  assign lane_ready = {lane1_ready, lane0_ready};

  // Depends only on registered state, so lane readies never reach ready_out
  // combinationally; a full target lane stalls even if it pops this cycle.
  assign ready_out = (state_reg != DRAIN) && !full[sel_reg];
  assign accept    = valid_in && ready_out;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic [7:0]    last_reg;

      assign full[gi]  = (count_reg == FULL_CNT);
      assign empty[gi] = (count_reg == '0);
      assign push[gi]  = accept && (sel_reg == 1'(gi));
      // Readiness of an empty lane is ignored.
      assign pop[gi]   = !empty[gi] && lane_ready[gi];

      // Storage carries no reset; occupancy alone defines validity.
      always_ff @(posedge clk_4f) begin
        if (push[gi]) begin
          mem[wr_ptr_reg] <= data_in;
        end
      end

      always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          last_reg   <= '0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            last_reg   <= mem[rd_ptr_reg];
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
          endcase
        end
      end

      // When the lane is empty, show the last byte popped instead of a stale slot.
      assign head[gi] = empty[gi] ? last_reg : mem[rd_ptr_reg];
    end
  endgenerate

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= IDLE;
      sel_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    if (accept) begin
      sel_next = ~sel_reg;
      cnt_next = cnt_reg + 16'd1;
    end
    case (state_reg)
      IDLE: begin
        // flush is ignored here; the first accept opens a burst.
        if (accept) begin
          state_next = STRIPE;
        end
      end
      STRIPE: begin
        if (flush) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing is accepted in DRAIN. Re-arm on lane 0 so the next burst
        // starts there.
        if (&empty) begin
          state_next = IDLE;
          sel_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        sel_next   = 1'b0;
      end
    endcase
  end

  assign validout0 = !empty[0];
  assign validout1 = !empty[1];
  assign dataout0  = head[0];
  assign dataout1  = head[1];
  assign sel_lane  = sel_reg;
  assign state_out = state_reg;
  assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_lane_stripe_ctrl.sv
// Directed bench for lane_stripe_ctrl (DEPTH = 4). Inputs change 1 time unit
// after a rising edge. Checks read registered state plus the combinational
// outputs for the inputs just applied.
module tb_lane_stripe_ctrl;

  logic        clk_4f = 1'b0;
  logic        reset_L;
  logic        valid_in;
  logic [7:0]  data_in;
  logic        ready_out;
  logic        flush;
  logic        lane0_ready;
  logic        lane1_ready;
  logic        validout0;
  logic        validout1;
  logic [7:0]  dataout0;
  logic [7:0]  dataout1;
  logic        sel_lane;
  logic [1:0]  state_out;
  logic [15:0] byte_cnt;

  int n_cmp = 0;
  int n_err = 0;

  lane_stripe_ctrl #(.DEPTH(4)) dut (
    .clk_4f      (clk_4f),
    .reset_L     (reset_L),
    .valid_in    (valid_in),
    .data_in     (data_in),
    .ready_out   (ready_out),
    .flush       (flush),
    .lane0_ready (lane0_ready),
    .lane1_ready (lane1_ready),
    .validout0   (validout0),
    .validout1   (validout1),
    .dataout0    (dataout0),
    .dataout1    (dataout1),
    .sel_lane    (sel_lane),
    .state_out   (state_out),
    .byte_cnt    (byte_cnt)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    reset_L = 1'b0; valid_in = 1'b0; data_in = 8'h00; flush = 1'b0;
    lane0_ready = 1'b0; lane1_ready = 1'b0;
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_sel", sel_lane, 0);
    chk("rst_v0", validout0, 0);
    chk("rst_v1", validout1, 0);
    chk("rst_cnt", byte_cnt, 0);
    chk("rst_ready", ready_out, 1);
    repeat (2) @(posedge clk_4f);
    #1;
    reset_L = 1'b1;
    tick;
    chk("post_rst_state", state_out, 0);
    chk("post_rst_v0", validout0, 0);

    // ---------------- stripe A0..A3 ----------------
    lane0_ready = 1'b1; lane1_ready = 1'b1;
    valid_in = 1'b1; data_in = 8'hA0;
    chk("st_ready", ready_out, 1);
    chk("st_sel0", sel_lane, 0);
    tick;
    chk("st_v0_a0", validout0, 1);
    chk("st_d0_a0", dataout0, 8'hA0);
    chk("st_v1_a0", validout1, 0);
    chk("st_state", state_out, 1);
    chk("st_sel1", sel_lane, 1);
    data_in = 8'hA1;
    tick;
    chk("st_v1_a1", validout1, 1);
    chk("st_d1_a1", dataout1, 8'hA1);
    chk("st_v0_a1", validout0, 0);
    data_in = 8'hA2;
    tick;
    chk("st_v0_a2", validout0, 1);
    chk("st_d0_a2", dataout0, 8'hA2);
    chk("st_v1_a2", validout1, 0);
    data_in = 8'hA3;
    tick;
    chk("st_v1_a3", validout1, 1);
    chk("st_d1_a3", dataout1, 8'hA3);
    chk("st_v0_a3", validout0, 0);
    chk("st_cnt", byte_cnt, 4);
    valid_in = 1'b0;
    tick;
    chk("st_empty0", validout0, 0);
    chk("st_empty1", validout1, 0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("st_drain", state_out, 2);
    chk("st_drain_rdy", ready_out, 0);
    tick;
    chk("st_idle", state_out, 0);
    chk("st_idle_sel", sel_lane, 0);
    chk("st_idle_rdy", ready_out, 1);

    // ---------------- full stall ----------------
    lane0_ready = 1'b0; lane1_ready = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'(i);
      chk("fs_accept_rdy", ready_out, 1);
      tick;
    end
    data_in = 8'h08;
    chk("fs_stall_rdy", ready_out, 0);
    chk("fs_stall_sel", sel_lane, 0);
    chk("fs_head0", dataout0, 8'h00);
    chk("fs_head1", dataout1, 8'h01);
    chk("fs_cnt", byte_cnt, 12);
    tick;
    chk("fs_still_stalled", ready_out, 0);
    chk("fs_cnt_hold", byte_cnt, 12);
    lane1_ready = 1'b1;
    chk("fs_l1_01", dataout1, 8'h01);
    tick;
    chk("fs_l1_03", dataout1, 8'h03);
    tick;
    chk("fs_l1_05", dataout1, 8'h05);
    tick;
    chk("fs_l1_07", dataout1, 8'h07);
    tick;
    chk("fs_l1_empty", validout1, 0);
    chk("fs_l0_still_full", ready_out, 0);
    lane1_ready = 1'b0;
    lane0_ready = 1'b1;
    chk("fs_full_pop_rdy", ready_out, 0);
    tick;
    chk("fs_resume_rdy", ready_out, 1);
    chk("fs_l0_02", dataout0, 8'h02);
    tick;
    chk("fs_cnt_08", byte_cnt, 13);
    chk("fs_l0_04", dataout0, 8'h04);
    chk("fs_sel_after08", sel_lane, 1);
    valid_in = 1'b0;
    tick;
    chk("fs_l0_06", dataout0, 8'h06);
    tick;
    chk("fs_l0_08", dataout0, 8'h08);
    tick;
    chk("fs_l0_empty", validout0, 0);
    lane0_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fs_drain", state_out, 2);
    tick;
    chk("fs_idle", state_out, 0);

    // ---------------- flush ----------------
    flush = 1'b1;
    tick;
    chk("fl_idle_flush_ignored", state_out, 0);
    flush = 1'b0;
    valid_in = 1'b1;
    data_in = 8'h10; tick;
    data_in = 8'h11; tick;
    data_in = 8'h12; tick;
    data_in = 8'h13; flush = 1'b1;
    chk("fl_4th_rdy", ready_out, 1);
    chk("fl_4th_sel", sel_lane, 1);
    tick;
    chk("fl_drain", state_out, 2);
    chk("fl_drain_rdy", ready_out, 0);
    chk("fl_d1_11", dataout1, 8'h11);
    data_in = 8'h99;
    tick;
    chk("fl_no_accept", byte_cnt, 17);
    lane0_ready = 1'b1; lane1_ready = 1'b1;
    chk("fl_d0_10", dataout0, 8'h10);
    tick;
    chk("fl_d0_12", dataout0, 8'h12);
    chk("fl_d1_13", dataout1, 8'h13);
    chk("fl_still_drain", state_out, 2);
    tick;
    chk("fl_e0", validout0, 0);
    chk("fl_e1", validout1, 0);
    chk("fl_drain_last", state_out, 2);
    tick;
    chk("fl_idle", state_out, 0);
    chk("fl_idle_sel", sel_lane, 0);
    flush = 1'b0;
    data_in = 8'h55;
    chk("fl_idle_rdy", ready_out, 1);
    tick;
    chk("fl_55_v0", validout0, 1);
    chk("fl_55_d0", dataout0, 8'h55);
    chk("fl_55_v1", validout1, 0);
    chk("fl_cnt", byte_cnt, 18);
    valid_in = 1'b0;
    tick;
    chk("fl_55_popped", validout0, 0);

    // ---------------- simultaneous push/pop on lane 1 ----------------
    lane0_ready = 1'b0; lane1_ready = 1'b0;
    valid_in = 1'b1;
    data_in = 8'h20; tick;
    data_in = 8'h21; tick;
    data_in = 8'h22; tick;
    data_in = 8'h23; tick;
    data_in = 8'h24; lane1_ready = 1'b1;
    chk("pp_d1_20", dataout1, 8'h20);
    tick;
    valid_in = 1'b0;
    chk("pp_d1_22", dataout1, 8'h22);
    chk("pp_cnt", byte_cnt, 23);
    chk("pp_d0_21", dataout0, 8'h21);
    tick;
    chk("pp_d1_24", dataout1, 8'h24);
    chk("pp_v1_24", validout1, 1);
    tick;
    chk("pp_l1_empty", validout1, 0);
    lane1_ready = 1'b0;

    // ---------------- mid-stream reset ----------------
    valid_in = 1'b1;
    data_in = 8'h26; tick;
    data_in = 8'h27; tick;
    valid_in = 1'b0;
    chk("mr_pre_v0", validout0, 1);
    chk("mr_pre_v1", validout1, 1);
    reset_L = 1'b0;
    #1;
    chk("mr_async_v0", validout0, 0);
    chk("mr_async_v1", validout1, 0);
    chk("mr_async_cnt", byte_cnt, 0);
    chk("mr_async_state", state_out, 0);
    chk("mr_async_rdy", ready_out, 1);
    chk("mr_async_sel", sel_lane, 0);
    @(posedge clk_4f);
    #1;
    reset_L = 1'b1;
    tick;
    chk("mr_post_v0", validout0, 0);
    chk("mr_post_v1", validout1, 0);
    tick;
    chk("mr_post2_v0", validout0, 0);
    chk("mr_post2_v1", validout1, 0);
    chk("mr_post_cnt", byte_cnt, 0);

    // ---------------- byte_cnt wrap ----------------
    lane0_ready = 1'b1; lane1_ready = 1'b1;
    valid_in = 1'b1; data_in = 8'h5A;
    repeat (65535) tick;
    chk("wr_ffff", byte_cnt, 16'hFFFF);
    tick;
    chk("wr_zero", byte_cnt, 16'h0000);
    valid_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
